// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between LSU consumers, the data-memory arbiter and the
// external data-memory channels. The arbiter takes the slave view; the
// surrounding consumers and memory take the master view.
interface data_mem_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
);
    logic [NUM_CONSUMERS-1:0] consumer_read_valid;
    logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] consumer_read_ready;
    logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS];

    logic [NUM_CONSUMERS-1:0] consumer_write_valid;
    logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] consumer_write_ready;

    logic [NUM_CHANNELS-1:0]  mem_read_valid;
    logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_read_ready;
    logic [DATA_BITS-1:0]     mem_read_data    [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]  mem_write_valid;
    logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     mem_write_data    [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Data-memory arbiter: NUM_CONSUMERS LSU requesters share NUM_CHANNELS
// memory channels. Each channel runs its own small FSM; idle channels pick
// up requests round-robin, lower channels having first pick each cycle.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | channel free, looking for an unowned consumer request
// READ_WAIT  | mem_read_valid up, waiting for mem_read_ready
// WRITE_WAIT | mem_write_valid up, waiting for mem_write_ready
// RELAY      | consumer ready held until the owner drops its valid
module data_mem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic               clk,
    input  logic               reset,
    data_mem_arbiter_if.slave  bus
);
    localparam int PTR_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} chan_state_t;

    chan_state_t          state_q [NUM_CHANNELS];
    chan_state_t          state_d [NUM_CHANNELS];
    logic [PTR_BITS-1:0]  owner_q [NUM_CHANNELS];
    logic [PTR_BITS-1:0]  owner_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] op_read_q, op_read_d;
    logic [NUM_CHANNELS-1:0] mem_rv_q, mem_rv_d, mem_wv_q, mem_wv_d;
    logic [ADDR_BITS-1:0] mem_ra_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] mem_ra_d [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] mem_wa_q [NUM_CHANNELS];
    logic [ADDR_BITS-1:0] mem_wa_d [NUM_CHANNELS];
    logic [DATA_BITS-1:0] mem_wd_q [NUM_CHANNELS];
    logic [DATA_BITS-1:0] mem_wd_d [NUM_CHANNELS];
    logic [PTR_BITS-1:0]  rr_q, rr_d;
    logic [NUM_CONSUMERS-1:0] c_rr_q, c_rr_d, c_wr_q, c_wr_d;
    logic [DATA_BITS-1:0] c_rd_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0] c_rd_d [NUM_CONSUMERS];
    logic [NUM_CONSUMERS-1:0] owned;

    // Consumers currently held by a busy channel are not eligible for a new grant.
    always_comb begin
        owned = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_q[c] != IDLE) owned[owner_q[c]] = 1'b1;
        end
    end

    // Per-channel next state, grant selection and registered-output next values.
    always_comb begin : p_next
        logic [NUM_CONSUMERS-1:0] claimed;
        logic                     found;
        int                       sel;
        int                       j;
        claimed   = '0;
        found     = 1'b0;
        sel       = 0;
        j         = 0;
        state_d   = state_q;
        owner_d   = owner_q;
        op_read_d = op_read_q;
        mem_rv_d  = mem_rv_q;
        mem_wv_d  = mem_wv_q;
        mem_ra_d  = mem_ra_q;
        mem_wa_d  = mem_wa_q;
        mem_wd_d  = mem_wd_q;
        rr_d      = rr_q;
        c_rd_d    = c_rd_q;
        c_rr_d    = '0;
        c_wr_d    = '0;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state_q[c])
                IDLE: begin
                    found = 1'b0;
                    sel   = 0;
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        j = (int'(rr_q) + k) % NUM_CONSUMERS;
                        if (!found && (bus.consumer_read_valid[j] || bus.consumer_write_valid[j])
                            && !owned[j] && !claimed[j]) begin
                            found = 1'b1;
                            sel   = j;
                        end
                    end
                    if (found) begin
                        claimed[sel] = 1'b1;
                        owner_d[c]   = PTR_BITS'(sel);
                        // Later (higher) channels overwrite, so the pointer follows the last grant.
                        rr_d         = PTR_BITS'((sel + 1) % NUM_CONSUMERS);
                        if (bus.consumer_read_valid[sel]) begin
                            op_read_d[c] = 1'b1;
                            state_d[c]   = READ_WAIT;
                            mem_rv_d[c]  = 1'b1;
                            mem_ra_d[c]  = bus.consumer_read_address[sel];
                        end else begin
                            op_read_d[c] = 1'b0;
                            state_d[c]   = WRITE_WAIT;
                            mem_wv_d[c]  = 1'b1;
                            mem_wa_d[c]  = bus.consumer_write_address[sel];
                            mem_wd_d[c]  = bus.consumer_write_data[sel];
                        end
                    end
                end
                READ_WAIT: begin
                    if (bus.mem_read_ready[c]) begin
                        mem_rv_d[c]         = 1'b0;
                        c_rd_d[owner_q[c]]  = bus.mem_read_data[c];
                        state_d[c]          = RELAY;
                    end
                end
                WRITE_WAIT: begin
                    if (bus.mem_write_ready[c]) begin
                        mem_wv_d[c] = 1'b0;
                        state_d[c]  = RELAY;
                    end
                end
                RELAY: begin
                    if (op_read_q[c] ? !bus.consumer_read_valid[owner_q[c]]
                                     : !bus.consumer_write_valid[owner_q[c]]) begin
                        state_d[c] = IDLE;
                    end
                end
                default: state_d[c] = IDLE;
            endcase
        end

        // Consumer ready follows the registered RELAY state of its owning channel.
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (state_d[c] == RELAY) begin
                if (op_read_d[c]) c_rr_d[owner_d[c]] = 1'b1;
                else              c_wr_d[owner_d[c]] = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c]  <= IDLE;
                owner_q[c]  <= '0;
                mem_ra_q[c] <= '0;
                mem_wa_q[c] <= '0;
                mem_wd_q[c] <= '0;
            end
            for (int i = 0; i < NUM_CONSUMERS; i++) c_rd_q[i] <= '0;
            op_read_q <= '0;
            mem_rv_q  <= '0;
            mem_wv_q  <= '0;
            rr_q      <= '0;
            c_rr_q    <= '0;
            c_wr_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            op_read_q <= op_read_d;
            mem_rv_q  <= mem_rv_d;
            mem_wv_q  <= mem_wv_d;
            mem_ra_q  <= mem_ra_d;
            mem_wa_q  <= mem_wa_d;
            mem_wd_q  <= mem_wd_d;
            rr_q      <= rr_d;
            c_rr_q    <= c_rr_d;
            c_wr_q    <= c_wr_d;
            c_rd_q    <= c_rd_d;
        end
    end

    assign bus.mem_read_valid       = mem_rv_q;
    assign bus.mem_read_address     = mem_ra_q;
    assign bus.mem_write_valid      = mem_wv_q;
    assign bus.mem_write_address    = mem_wa_q;
    assign bus.mem_write_data       = mem_wd_q;
    assign bus.consumer_read_ready  = c_rr_q;
    assign bus.consumer_write_ready = c_wr_q;
    assign bus.consumer_read_data   = c_rd_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: the bench plays both the consumers and a
// behavioural data memory with programmable response latency.
module tb_data_mem_arbiter;
    localparam int NC = 8;
    localparam int NH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NH)) bus ();

    data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(NC), .NUM_CHANNELS(NH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0]  mem_model [256];
    int          mem_lat;
    int          rd_cnt [NH];
    int          wr_cnt [NH];
    logic [7:0]  exp_rd [NC][$];
    logic [15:0] exp_wr [NC][$];
    logic [NC-1:0] seen_rr, seen_wr;
    int          rd_done [NC];
    int          wr_done [NC];
    logic [7:0]  last_rd [NC];
    int          order [$];

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Consumer scoreboard and memory responder, evaluated on the falling edge.
    task automatic service();
        logic [7:0]  e;
        logic [15:0] w;
        for (int i = 0; i < NC; i++) begin
            if (bus.consumer_read_ready[i] && !seen_rr[i]) begin
                checks++;
                if (exp_rd[i].size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected consumer=%0d got=%0d expected=none", i, bus.consumer_read_data[i]);
                end else begin
                    e = exp_rd[i].pop_front();
                    if (bus.consumer_read_data[i] !== e) begin
                        failures++;
                        $display("FAIL rd_data consumer=%0d got=%0d expected=%0d", i, bus.consumer_read_data[i], e);
                    end
                end
                last_rd[i] = bus.consumer_read_data[i];
                rd_done[i]++;
                order.push_back(2 * i);
                bus.consumer_read_valid[i] = 1'b0;
            end
            seen_rr[i] = bus.consumer_read_ready[i];
            if (bus.consumer_write_ready[i] && !seen_wr[i]) begin
                checks++;
                if (exp_wr[i].size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected consumer=%0d got=ready expected=none", i);
                end else begin
                    w = exp_wr[i].pop_front();
                    if (mem_model[w[15:8]] !== w[7:0]) begin
                        failures++;
                        $display("FAIL wr_commit consumer=%0d addr=%0d got=%0d expected=%0d", i, w[15:8], mem_model[w[15:8]], w[7:0]);
                    end
                end
                wr_done[i]++;
                order.push_back(2 * i + 1);
                bus.consumer_write_valid[i] = 1'b0;
            end
            seen_wr[i] = bus.consumer_write_ready[i];
        end
        for (int c = 0; c < NH; c++) begin
            if (bus.mem_read_ready[c]) bus.mem_read_ready[c] = 1'b0;
            else if (bus.mem_read_valid[c]) begin
                rd_cnt[c]++;
                if (rd_cnt[c] > mem_lat) begin
                    bus.mem_read_ready[c] = 1'b1;
                    bus.mem_read_data[c]  = mem_model[bus.mem_read_address[c]];
                    rd_cnt[c] = 0;
                end
            end else rd_cnt[c] = 0;
            if (bus.mem_write_ready[c]) bus.mem_write_ready[c] = 1'b0;
            else if (bus.mem_write_valid[c]) begin
                wr_cnt[c]++;
                if (wr_cnt[c] > mem_lat) begin
                    bus.mem_write_ready[c] = 1'b1;
                    mem_model[bus.mem_write_address[c]] = bus.mem_write_data[c];
                    wr_cnt[c] = 0;
                end
            end else wr_cnt[c] = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        service();
        @(posedge clk);
        #2;
    endtask

    task automatic issue_read(input int i, input logic [7:0] a);
        bus.consumer_read_address[i] = a;
        bus.consumer_read_valid[i]   = 1'b1;
        exp_rd[i].push_back(mem_model[a]);
    endtask

    task automatic issue_write(input int i, input logic [7:0] a, input logic [7:0] d);
        bus.consumer_write_address[i] = a;
        bus.consumer_write_data[i]    = d;
        bus.consumer_write_valid[i]   = 1'b1;
        exp_wr[i].push_back({a, d});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0 || bus.mem_write_valid !== 4'b0) begin
            failures++;
            $display("FAIL reset_mem_valid got=%b/%b expected=0000/0000", bus.mem_read_valid, bus.mem_write_valid);
        end
        checks++;
        if (bus.consumer_read_ready !== 8'b0 || bus.consumer_write_ready !== 8'b0) begin
            failures++;
            $display("FAIL reset_cons_ready got=%b/%b expected=0/0", bus.consumer_read_ready, bus.consumer_write_ready);
        end
        for (int c = 0; c < NH; c++) begin
            checks++;
            if (bus.mem_read_address[c] !== 8'd0 || bus.mem_write_address[c] !== 8'd0 || bus.mem_write_data[c] !== 8'd0) begin
                failures++;
                $display("FAIL reset_mem_bus ch=%0d got=%0d/%0d/%0d expected=0/0/0", c,
                         bus.mem_read_address[c], bus.mem_write_address[c], bus.mem_write_data[c]);
            end
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (bus.consumer_read_data[i] !== 8'd0) begin
                failures++;
                $display("FAIL reset_rd_data consumer=%0d got=%0d expected=0", i, bus.consumer_read_data[i]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int n;
        mem_lat = 3;
        for (int i = 0; i < NC; i++) begin
            mem_model[100 + i] = 8'(i * 3 + 1);
            issue_read(i, 8'(100 + i));
        end
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b1111 || dut.rr_q !== 3'd4) begin
            failures++;
            $display("FAIL contention_round1 valid=%b rr=%0d expected=1111 rr=4", bus.mem_read_valid, dut.rr_q);
        end
        for (int c = 0; c < NH; c++) begin
            checks++;
            if (bus.mem_read_address[c] !== 8'(100 + c)) begin
                failures++;
                $display("FAIL contention_addr1 ch=%0d got=%0d expected=%0d", c, bus.mem_read_address[c], 100 + c);
            end
        end
        n = 0;
        while (!(bus.mem_read_valid[0] && bus.mem_read_address[0] != 8'd100) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.mem_read_valid !== 4'b1111 || dut.rr_q !== 3'd0) begin
            failures++;
            $display("FAIL contention_round2 valid=%b rr=%0d expected=1111 rr=0", bus.mem_read_valid, dut.rr_q);
        end
        for (int c = 0; c < NH; c++) begin
            checks++;
            if (bus.mem_read_address[c] !== 8'(104 + c)) begin
                failures++;
                $display("FAIL contention_addr2 ch=%0d got=%0d expected=%0d", c, bus.mem_read_address[c], 104 + c);
            end
        end
        n = 0;
        while (bus.consumer_read_valid != 8'b0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (bus.consumer_read_valid !== 8'b0) begin
            failures++;
            $display("FAIL contention_timeout pending=%b expected=00000000", bus.consumer_read_valid);
        end
        tick();
    endtask

    task automatic test_single_read();
        int n;
        int snap;
        mem_lat = 5;
        mem_model[5] = 8'd7;
        snap = rd_done[2];
        issue_read(2, 8'd5);
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0001 || bus.mem_read_address[0] !== 8'd5) begin
            failures++;
            $display("FAIL single_read_issue valid=%b addr=%0d expected=0001 addr=5", bus.mem_read_valid, bus.mem_read_address[0]);
        end
        n = 0;
        while (rd_done[2] == snap && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (rd_done[2] == snap) begin
            failures++;
            $display("FAIL single_read_timeout got=no_ready expected=ready");
        end
        tick();
        checks++;
        if (bus.consumer_read_ready !== 8'b0 || dut.rr_q !== 3'd3) begin
            failures++;
            $display("FAIL single_read_release ready=%b rr=%0d expected=0 rr=3", bus.consumer_read_ready, dut.rr_q);
        end
    endtask

    task automatic test_latency();
        mem_lat = 0;
        issue_read(4, 8'd9);
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0001 || bus.mem_read_address[0] !== 8'd9) begin
            failures++;
            $display("FAIL latency_mem_valid got=%b addr=%0d expected=0001 addr=9", bus.mem_read_valid, bus.mem_read_address[0]);
        end
        tick();
        checks++;
        if (bus.consumer_read_ready !== 8'b0001_0000) begin
            failures++;
            $display("FAIL latency_ready got=%b expected=00010000", bus.consumer_read_ready);
        end
        tick();
        checks++;
        if (bus.consumer_read_ready !== 8'b0) begin
            failures++;
            $display("FAIL latency_release got=%b expected=00000000", bus.consumer_read_ready);
        end
        tick();
    endtask

    task automatic test_single_write();
        int n;
        int snap;
        mem_lat = 2;
        snap = wr_done[0];
        issue_write(0, 8'd20, 8'd40);
        tick();
        checks++;
        if (bus.mem_write_valid !== 4'b0001 || bus.mem_write_address[0] !== 8'd20 ||
            bus.mem_write_data[0] !== 8'd40 || bus.mem_read_valid !== 4'b0) begin
            failures++;
            $display("FAIL single_write_issue valid=%b addr=%0d data=%0d rvalid=%b expected=0001 20 40 0000",
                     bus.mem_write_valid, bus.mem_write_address[0], bus.mem_write_data[0], bus.mem_read_valid);
        end
        n = 0;
        while (wr_done[0] == snap && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (wr_done[0] == snap || mem_model[20] !== 8'd40) begin
            failures++;
            $display("FAIL single_write_done got=%0d expected=40", mem_model[20]);
        end
        tick();
    endtask

    task automatic test_read_write();
        int n;
        int snap;
        mem_lat = 1;
        mem_model[30] = 8'd33;
        order.delete();
        snap = wr_done[3];
        issue_read(3, 8'd30);
        issue_write(3, 8'd31, 8'd99);
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0001 || bus.mem_write_valid !== 4'b0) begin
            failures++;
            $display("FAIL rw_read_first got=%b/%b expected=0001/0000", bus.mem_read_valid, bus.mem_write_valid);
        end
        n = 0;
        while (wr_done[3] == snap && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (order.size() != 2 || order[0] != 6 || order[1] != 7) begin
            failures++;
            $display("FAIL rw_order got_size=%0d expected=read_then_write", order.size());
        end
        tick();
    endtask

    task automatic test_drop_early();
        int n;
        int snap;
        mem_lat = 4;
        mem_model[60] = 8'hA5;
        snap = rd_done[5];
        issue_read(5, 8'd60);
        tick();
        bus.consumer_read_valid[5] = 1'b0;
        n = 0;
        while (!bus.consumer_read_ready[5] && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.consumer_read_ready[5]) begin
            failures++;
            $display("FAIL drop_early_ready got=0 expected=1");
        end
        tick();
        checks++;
        if (bus.consumer_read_ready !== 8'b0 || rd_done[5] != snap + 1) begin
            failures++;
            $display("FAIL drop_early_release ready=%b done=%0d expected=0 done=%0d", bus.consumer_read_ready, rd_done[5], snap + 1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        mem_lat = 20;
        mem_model[50] = 8'd11;
        mem_model[56] = 8'd66;
        issue_read(1, 8'd50);
        issue_read(6, 8'd56);
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0011 || bus.mem_read_address[0] !== 8'd56 || bus.mem_read_address[1] !== 8'd50) begin
            failures++;
            $display("FAIL reset_mid_pre valid=%b a0=%0d a1=%0d expected=0011 56 50",
                     bus.mem_read_valid, bus.mem_read_address[0], bus.mem_read_address[1]);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0 || bus.mem_read_address[0] !== 8'd0 ||
            bus.mem_read_address[1] !== 8'd0 || bus.consumer_read_ready !== 8'b0) begin
            failures++;
            $display("FAIL reset_mid_clear valid=%b a0=%0d a1=%0d ready=%b expected=0",
                     bus.mem_read_valid, bus.mem_read_address[0], bus.mem_read_address[1], bus.consumer_read_ready);
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (bus.consumer_read_data[i] !== 8'd0) begin
                failures++;
                $display("FAIL reset_mid_data consumer=%0d got=%0d expected=0", i, bus.consumer_read_data[i]);
            end
        end
        reset   = 1'b0;
        mem_lat = 2;
        tick();
        checks++;
        if (bus.mem_read_valid !== 4'b0011 || bus.mem_read_address[0] !== 8'd50 || bus.mem_read_address[1] !== 8'd56) begin
            failures++;
            $display("FAIL reset_mid_reissue valid=%b a0=%0d a1=%0d expected=0011 50 56",
                     bus.mem_read_valid, bus.mem_read_address[0], bus.mem_read_address[1]);
        end
        n = 0;
        while (bus.consumer_read_valid != 8'b0 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus.consumer_read_valid !== 8'b0) begin
            failures++;
            $display("FAIL reset_mid_timeout pending=%b expected=00000000", bus.consumer_read_valid);
        end
        tick();
    endtask

    task automatic test_matmul();
        int         step [6];
        bit         busy [6];
        int         snap [6];
        logic [7:0] opnd [6][4];
        logic [7:0] a_tab [4];
        logic [7:0] b_tab [6];
        logic [7:0] c_exp [6];
        logic [7:0] addr;
        int         r, col, n;
        bit         all_done;
        a_tab = '{8'd6, 8'd2, 8'd10, 8'd0};
        b_tab = '{8'd4, 8'd5, 8'd6, 8'd1, 8'd1, 8'd1};
        c_exp = '{8'd26, 8'd32, 8'd38, 8'd40, 8'd50, 8'd60};
        for (int k = 0; k < 4; k++) mem_model[k] = a_tab[k];
        for (int k = 0; k < 6; k++) mem_model[8 + k] = b_tab[k];
        mem_lat = 1;
        for (int t = 0; t < 6; t++) begin
            step[t] = 0;
            busy[t] = 1'b0;
            snap[t] = 0;
        end
        n = 0;
        all_done = 1'b0;
        while (!all_done && n < 3000) begin
            all_done = 1'b1;
            for (int t = 0; t < 6; t++) begin
                r   = t / 3;
                col = t % 3;
                if (busy[t]) begin
                    if (step[t] < 4 && rd_done[t] != snap[t]) begin
                        opnd[t][step[t]] = last_rd[t];
                        step[t]++;
                        busy[t] = 1'b0;
                    end else if (step[t] == 4 && wr_done[t] != snap[t]) begin
                        step[t] = 5;
                        busy[t] = 1'b0;
                    end
                end
                if (!busy[t] && step[t] < 4) begin
                    case (step[t])
                        0:       addr = 8'(2 * r);
                        1:       addr = 8'(8 + col);
                        2:       addr = 8'(2 * r + 1);
                        default: addr = 8'(11 + col);
                    endcase
                    snap[t] = rd_done[t];
                    issue_read(t, addr);
                    busy[t] = 1'b1;
                end else if (!busy[t] && step[t] == 4) begin
                    snap[t] = wr_done[t];
                    issue_write(t, 8'(20 + t), 8'(opnd[t][0] * opnd[t][1] + opnd[t][2] * opnd[t][3]));
                    busy[t] = 1'b1;
                end
                if (step[t] != 5) all_done = 1'b0;
            end
            if (!all_done) begin
                tick();
                n++;
            end
        end
        checks++;
        if (!all_done) begin
            failures++;
            $display("FAIL matmul_timeout got=unfinished expected=all_threads_done");
        end
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (mem_model[20 + t] !== c_exp[t]) begin
                failures++;
                $display("FAIL matmul_c addr=%0d got=%0d expected=%0d", 20 + t, mem_model[20 + t], c_exp[t]);
            end
        end
    endtask

    initial begin
        int pending;
        reset = 1'b1;
        mem_lat = 0;
        bus.consumer_read_valid  = '0;
        bus.consumer_write_valid = '0;
        bus.mem_read_ready       = '0;
        bus.mem_write_ready      = '0;
        for (int i = 0; i < NC; i++) begin
            bus.consumer_read_address[i]  = '0;
            bus.consumer_write_address[i] = '0;
            bus.consumer_write_data[i]    = '0;
            rd_done[i] = 0;
            wr_done[i] = 0;
            last_rd[i] = '0;
        end
        for (int c = 0; c < NH; c++) begin
            bus.mem_read_data[c] = '0;
            rd_cnt[c] = 0;
            wr_cnt[c] = 0;
        end
        for (int k = 0; k < 256; k++) mem_model[k] = 8'(k * 7 + 3);
        seen_rr = '0;
        seen_wr = '0;

        test_reset();
        test_contention();
        test_single_read();
        test_latency();
        test_single_write();
        test_read_write();
        test_drop_early();
        test_reset_mid();
        test_matmul();

        pending = 0;
        for (int i = 0; i < NC; i++) pending += exp_rd[i].size() + exp_wr[i].size();
        checks++;
        if (pending != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", pending);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
